// File: rtl/vram_rect_fill_if.sv
// VRAM port A bundle between the rectangle-fill engine and the frame RAM.
interface vram_rect_fill_if;
    logic        vram_enable;
    logic        vram_rw;
    logic [15:0] vram_addr;
    logic [15:0] vram_wdata;
    logic [15:0] vram_rdata;

    modport master (
        output vram_enable,
        output vram_rw,
        output vram_addr,
        output vram_wdata,
        input  vram_rdata
    );

    modport slave (
        input  vram_enable,
        input  vram_rw,
        input  vram_addr,
        input  vram_wdata,
        output vram_rdata
    );
endinterface

// File: rtl/vram_rect_fill.sv
// Clipped rectangle fill of a 4-bit-per-pixel framebuffer, four pixels per word.
module vram_rect_fill #(
    parameter int H_PIXELS      = 320,
    parameter int V_PIXELS      = 240,
    parameter int WORDS_PER_ROW = 80,
    parameter int READ_LATENCY  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [8:0]       x0,
    input  logic [7:0]       y0,
    input  logic [8:0]       width,
    input  logic [7:0]       height,
    input  logic [3:0]       colour,
    output logic             busy,
    output logic             done,
    vram_rect_fill_if.master vram
);

    typedef enum logic [2:0] {
        IDLE, SETUP, FULL_WR, RD, RD_WAIT, MERGE_WR, NEXT, DONE
    } state_t;

    state_t state_q, state_d;

    logic [8:0]  x0_q, w_q;
    logic [7:0]  y0_q, h_q;
    logic [3:0]  col_q;
    logic [6:0]  wx_q;
    logic [7:0]  y_q;
    logic [15:0] base_q;
    logic [1:0]  cnt_q;
    logic [15:0] addr_q, wdata_q;

    logic [9:0]  x_end, y_end, x1, y1;
    logic        empty, row_last, line_last;
    logic [6:0]  nwx, cur_wx;
    logic [7:0]  ny;
    logic [15:0] nbase, cur_base, cur_addr, merged;
    logic [3:0]  cur_mask;

    function automatic logic [3:0] mask_of(
        input logic [6:0] w,
        input logic [9:0] lo,
        input logic [9:0] hi
    );
        logic [9:0] px;
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            px   = {1'b0, w, 2'(i)};
            m[i] = (px >= lo) && (px <= hi);
        end
        return m;
    endfunction

    // 10-bit sums keep x0+width and y0+height from wrapping before the clip.
    assign x_end = {1'b0, x0_q} + {1'b0, w_q};
    assign y_end = {2'b0, y0_q} + {2'b0, h_q};
    assign x1 = (x_end < 10'(H_PIXELS) ? x_end : 10'(H_PIXELS)) - 10'd1;
    assign y1 = (y_end < 10'(V_PIXELS) ? y_end : 10'(V_PIXELS)) - 10'd1;

    assign empty = (w_q == '0) || (h_q == '0)
                || ({1'b0, x0_q} >= 10'(H_PIXELS))
                || ({2'b0, y0_q} >= 10'(V_PIXELS));

    assign row_last  = {1'b0, wx_q} == x1[9:2];
    assign line_last = {2'b0, y_q} == y1;

    assign nwx   = row_last ? x0_q[8:2] : wx_q + 7'd1;
    assign ny    = row_last ? y_q + 8'd1 : y_q;
    assign nbase = row_last ? base_q + 16'(WORDS_PER_ROW) : base_q;

    // In NEXT the following word is decoded early so it costs no extra cycle.
    assign cur_wx   = (state_q == NEXT) ? nwx : wx_q;
    assign cur_base = (state_q == NEXT) ? nbase : base_q;
    assign cur_addr = cur_base + {9'd0, cur_wx};
    assign cur_mask = mask_of(cur_wx, {1'b0, x0_q}, x1);

    always_comb begin
        merged = vram.vram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (cur_mask[i]) merged[4*(3-i) +: 4] = col_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = SETUP;
            SETUP: begin
                if (empty)                  state_d = DONE;
                else if (cur_mask == 4'hF)  state_d = FULL_WR;
                else                        state_d = RD;
            end
            FULL_WR:  state_d = NEXT;
            RD:       state_d = RD_WAIT;
            RD_WAIT:  if (cnt_q == 2'(READ_LATENCY - 1)) state_d = MERGE_WR;
            MERGE_WR: state_d = NEXT;
            NEXT: begin
                if (row_last && line_last)  state_d = DONE;
                else if (cur_mask == 4'hF)  state_d = FULL_WR;
                else                        state_d = RD;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            w_q     <= '0;
            y0_q    <= '0;
            h_q     <= '0;
            col_q   <= '0;
            wx_q    <= '0;
            y_q     <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                x0_q   <= x0;
                w_q    <= width;
                y0_q   <= y0;
                h_q    <= height;
                col_q  <= colour;
                wx_q   <= x0[8:2];
                y_q    <= y0;
                base_q <= 16'(y0) * 16'(WORDS_PER_ROW);
            end
            if (state_q == NEXT) begin
                wx_q   <= nwx;
                y_q    <= ny;
                base_q <= nbase;
            end
            if (state_q == RD)           cnt_q <= '0;
            else if (state_q == RD_WAIT) cnt_q <= cnt_q + 2'd1;
            if (state_d == FULL_WR || state_d == RD) addr_q <= cur_addr;
            if (state_d == FULL_WR)  wdata_q <= {4{col_q}};
            if (state_d == MERGE_WR) wdata_q <= merged;
        end
    end

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

    assign vram.vram_enable = (state_q == FULL_WR) || (state_q == RD)
                           || (state_q == MERGE_WR);
    assign vram.vram_rw     = (state_q == FULL_WR) || (state_q == MERGE_WR);
    assign vram.vram_addr   = addr_q;
    assign vram.vram_wdata  = wdata_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Random and directed fills against a pixel-level framebuffer model with a scoreboard.
module tb_vram_rect_fill;

    localparam int NWORDS = 19200;

    typedef struct {
        bit        rw;
        int        addr;
        bit [15:0] wdata;
    } acc_t;

    typedef struct {
        int cyc;
        int busy;
    } done_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] width;
    logic [7:0] height;
    logic [3:0] colour;
    logic       busy;
    logic       done;

    vram_rect_fill_if vif ();

    vram_rect_fill dut (
        .clock   (clk),
        .reset_n (reset_n),
        .start   (start),
        .x0      (x0),
        .y0      (y0),
        .width   (width),
        .height  (height),
        .colour  (colour),
        .busy    (busy),
        .done    (done),
        .vram    (vif)
    );

    bit [15:0] ram [0:NWORDS-1];
    bit [15:0] fb  [0:NWORDS-1];
    acc_t      exp_q[$];
    done_t     done_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_cnt = 0;

    bit        poke_en = 0;
    int        poke_addr = 0;
    bit [15:0] poke_data = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Port A RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (vif.vram_enable && vif.vram_addr < 16'(NWORDS)) begin
            if (vif.vram_rw) ram[vif.vram_addr] <= vif.vram_wdata;
            else             vif.vram_rdata <= ram[vif.vram_addr];
        end
    end

    acc_t  e;
    done_t d;

    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            if (vif.vram_enable) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL access_extra: got rw=%0d addr=%0d wdata=%h, want no access",
                             vif.vram_rw, vif.vram_addr, vif.vram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (vif.vram_rw !== e.rw || vif.vram_addr !== 16'(e.addr)
                        || (e.rw && vif.vram_wdata !== e.wdata)) begin
                        failures++;
                        $display("FAIL access: got rw=%0d addr=%0d wdata=%h, want rw=%0d addr=%0d wdata=%h",
                                 vif.vram_rw, vif.vram_addr, vif.vram_wdata,
                                 e.rw, e.addr, e.wdata);
                    end
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_extra: got done=1 at cycle %0d, want none", cyc);
                end else begin
                    d = done_q.pop_front();
                    if (cyc != d.cyc || busy_cnt != d.busy) begin
                        failures++;
                        $display("FAIL done_timing: got cycle=%0d busy=%0d, want cycle=%0d busy=%0d",
                                 cyc, busy_cnt, d.cyc, d.busy);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    // Pixel-level model: every covered pixel takes the colour, words are visited
    // row by row left to right, words with any uncovered pixel are read first.
    task automatic model_fill(input int ax, input int ay, input int aw,
                              input int ah, input int ac, output int cost);
        int xe, ye, a, covered;
        bit [15:0] nw;
        acc_t t;
        cost = 0;
        if (aw == 0 || ah == 0 || ax >= 320 || ay >= 240) return;
        xe = (ax + aw < 320) ? ax + aw : 320;
        ye = (ay + ah < 240) ? ay + ah : 240;
        for (int y = ay; y < ye; y++) begin
            for (int w = ax / 4; w <= (xe - 1) / 4; w++) begin
                a = y * 80 + w;
                nw = fb[a];
                covered = 0;
                for (int p = 0; p < 4; p++) begin
                    if (w * 4 + p >= ax && w * 4 + p < xe) begin
                        nw[15 - 4 * p -: 4] = 4'(ac);
                        covered++;
                    end
                end
                if (covered != 4) begin
                    t.rw = 0; t.addr = a; t.wdata = 0;
                    exp_q.push_back(t);
                    cost += 4;
                end else begin
                    cost += 2;
                end
                t.rw = 1; t.addr = a; t.wdata = nw;
                exp_q.push_back(t);
                fb[a] = nw;
            end
        end
    endtask

    task automatic set_inputs(input int ax, input int ay, input int aw,
                              input int ah, input int ac);
        x0 = 9'(ax);
        y0 = 8'(ay);
        width = 9'(aw);
        height = 8'(ah);
        colour = 4'(ac);
    endtask

    task automatic fill(input int ax, input int ay, input int aw,
                        input int ah, input int ac, input bit wait_done);
        int cost, n;
        done_t dd;
        @(negedge clk);
        set_inputs(ax, ay, aw, ah, ac);
        model_fill(ax, ay, aw, ah, ac, cost);
        start = 1;
        @(negedge clk);
        dd.cyc = cyc + 1 + cost;
        dd.busy = 1 + cost;
        done_q.push_back(dd);
        if (cost > 0) begin
            set_inputs($urandom_range(0, 319), $urandom_range(0, 239),
                       $urandom_range(1, 300), $urandom_range(1, 200),
                       $urandom_range(0, 15));
            @(negedge clk);
        end
        start = 0;
        if (!wait_done) return;
        n = 0;
        while (!done && n < 50000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done after %0d cycles, want done", n);
            return;
        end
        set_inputs(0, 0, 8, 1, 9);
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done: got busy=%0d, want busy=0", busy);
        end
    endtask

    task automatic poke(input int a, input bit [15:0] v);
        @(negedge clk);
        poke_en = 1;
        poke_addr = a;
        poke_data = v;
        fb[a] = v;
        @(negedge clk);
        poke_en = 0;
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (busy !== 0 || done !== 0 || vif.vram_enable !== 0 || vif.vram_rw !== 0
            || vif.vram_addr !== 0 || vif.vram_wdata !== 0) begin
            failures++;
            $display("FAIL %s: got busy=%0d done=%0d en=%0d rw=%0d addr=%0d wdata=%h, want all 0",
                     name, busy, done, vif.vram_enable, vif.vram_rw,
                     vif.vram_addr, vif.vram_wdata);
        end
    endtask

    initial begin
        int bad;
        reset_n = 1;
        start = 0;
        set_inputs(0, 0, 0, 0, 0);
        #2 reset_n = 0;
        #1 check_idle_outputs("reset_state");
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        reset_n = 1;
        repeat (2) @(negedge clk);

        fill(4, 2, 8, 2, 4'hA, 1);
        poke(0, 16'h1234);
        fill(1, 0, 2, 1, 4'hF, 1);
        fill(318, 239, 10, 10, 4'h3, 1);
        fill(10, 10, 0, 5, 1, 1);
        fill(10, 10, 5, 0, 1, 1);
        fill(320, 10, 5, 5, 1, 1);
        fill(10, 240, 5, 5, 1, 1);
        fill(511, 255, 511, 255, 2, 1);
        fill(0, 0, 511, 1, 6, 1);

        for (int i = 0; i < 25; i++) begin
            fill($urandom_range(0, 330), $urandom_range(0, 245),
                 $urandom_range(0, 48), $urandom_range(0, 10),
                 $urandom_range(0, 15), 1);
        end

        fill(0, 0, 320, 10, 7, 0);
        repeat (40) @(negedge clk);
        #2 reset_n = 0;
        exp_q.delete();
        done_q.delete();
        #1 check_idle_outputs("reset_mid_fill");
        repeat (2) @(negedge clk);
        for (int i = 0; i < NWORDS; i++) fb[i] = ram[i];
        reset_n = 1;
        repeat (5) @(negedge clk);
        check_idle_outputs("after_reset_idle");

        fill(0, 0, 320, 240, 4'h5, 1);
        for (int i = 0; i < 5; i++) begin
            fill($urandom_range(0, 319), $urandom_range(0, 239),
                 $urandom_range(1, 40), $urandom_range(1, 8),
                 $urandom_range(0, 15), 1);
        end
        repeat (4) @(negedge clk);

        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL pending: got %0d accesses %0d dones outstanding, want 0 0",
                     exp_q.size(), done_q.size());
        end
        bad = 0;
        for (int i = 0; i < NWORDS; i++) if (fb[i] != ram[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL framebuffer: got %0d differing words, want 0", bad);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
